alu_interface: RTL

ALU_INTERFACE -- requirements
Module: alu_interface

---
 rtl/alu_interface_pkg.sv | 24 ++
 rtl/alu_interface_if.sv | 52 +++++
 rtl/alu_interface.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_interface_pkg.sv
// -----------------------------------------------------------------------------
// alu_interface_pkg
// Shared definitions for the UART <-> ALU glue block: default widths of the
// ALU operands, result and opcode, the serial byte width, and the sequencing
// FSM state encoding.
// -----------------------------------------------------------------------------
package alu_interface_pkg;

  localparam int CANT_BUS_ENTRADA_DEF = 6;  // ALU operand width
  localparam int CANT_BUS_SALIDA_DEF  = 6;  // ALU result width
  localparam int CANT_BITS_OPCODE_DEF = 4;  // ALU opcode width
  localparam int WIDTH_WORD_DEF       = 8;  // UART byte width

  // Sequencing FSM: three received bytes (op1, op2, opcode), then one
  // result byte sent back through the transmitter.
  typedef enum logic [2:0] {
    ESPERA_OP1    = 3'd0,
    ESPERA_OP2    = 3'd1,
    ESPERA_OPCODE = 3'd2,
    ENVIO         = 3'd3,
    ESPERA_TX     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_interface_if.sv
// -----------------------------------------------------------------------------
// alu_interface_if
// Bundles the UART rx/tx handshake and the ALU operand/result bus seen by
// alu_interface.
//   slave  : view of alu_interface (consumes rx/tx/result, drives ALU + tx)
//   master : view of the surrounding top (UARTs, ALU, or a testbench)
// Signals:
//   i_rx_data   received byte, valid while i_rx_done=1
//   i_rx_done   one-cycle pulse, new byte available
//   i_tx_done   one-cycle pulse, transmitter finished the byte
//   i_resultado signed ALU result (combinational from the ALU)
//   o_operando_1/o_operando_2  signed ALU operands
//   o_opcode    ALU opcode
//   o_tx_data   byte to transmitter
//   o_tx_start  one-cycle pulse, start transmission
//   o_busy      high while a result is being sent
//   o_overrun   sticky, a received byte was dropped
// -----------------------------------------------------------------------------
interface alu_interface_if
  import alu_interface_pkg::*;
#(
  parameter int CANT_BUS_ENTRADA = CANT_BUS_ENTRADA_DEF,
  parameter int CANT_BUS_SALIDA  = CANT_BUS_SALIDA_DEF,
  parameter int CANT_BITS_OPCODE = CANT_BITS_OPCODE_DEF,
  parameter int WIDTH_WORD       = WIDTH_WORD_DEF
);

  logic        [WIDTH_WORD-1:0]       i_rx_data;
  logic                               i_rx_done;
  logic                               i_tx_done;
  logic signed [CANT_BUS_SALIDA-1:0]  i_resultado;
  logic signed [CANT_BUS_ENTRADA-1:0] o_operando_1;
  logic signed [CANT_BUS_ENTRADA-1:0] o_operando_2;
  logic        [CANT_BITS_OPCODE-1:0] o_opcode;
  logic        [WIDTH_WORD-1:0]       o_tx_data;
  logic                               o_tx_start;
  logic                               o_busy;
  logic                               o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_resultado,
    output o_operando_1, o_operando_2, o_opcode,
           o_tx_data, o_tx_start, o_busy, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_resultado,
    input  o_operando_1, o_operando_2, o_opcode,
           o_tx_data, o_tx_start, o_busy, o_overrun
  );

endinterface

// File: rtl/alu_interface.sv
// -----------------------------------------------------------------------------
// alu_interface
// Collects operand 1, operand 2 and opcode from three consecutive UART bytes,
// presents them to an external ALU, then sends the sign-extended ALU result
// back as one UART byte. Bytes arriving while a result is in flight are
// dropped and flagged on the sticky o_overrun.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      alu_interface_if.slave (rx/tx handshake and ALU bus)
// Timing: opcode byte accepted in cycle N -> o_tx_start high in cycle N+2.
// -----------------------------------------------------------------------------
module alu_interface
  import alu_interface_pkg::*;
#(
  parameter int CANT_BUS_ENTRADA = CANT_BUS_ENTRADA_DEF,
  parameter int CANT_BUS_SALIDA  = CANT_BUS_SALIDA_DEF,
  parameter int CANT_BITS_OPCODE = CANT_BITS_OPCODE_DEF,
  parameter int WIDTH_WORD       = WIDTH_WORD_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  alu_interface_if.slave  bus
);

  state_t state, state_next;

  logic load_op1, load_op2, load_opcode, send, drop;

  logic signed [CANT_BUS_ENTRADA-1:0] operando_1_q, operando_2_q;
  logic        [CANT_BITS_OPCODE-1:0] opcode_q;
  logic        [WIDTH_WORD-1:0]       tx_data_q;
  logic                               tx_start_q, overrun_q;
  logic signed [WIDTH_WORD-1:0]       result_ext;

  // Size cast of a signed operand sign-extends it.
  assign result_ext = WIDTH_WORD'(bus.i_resultado);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ESPERA_OP1;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    load_op1    = 1'b0;
    load_op2    = 1'b0;
    load_opcode = 1'b0;
    send        = 1'b0;
    drop        = 1'b0;
    unique case (state)
      ESPERA_OP1: if (bus.i_rx_done) begin
        load_op1   = 1'b1;
        state_next = ESPERA_OP2;
      end
      ESPERA_OP2: if (bus.i_rx_done) begin
        load_op2   = 1'b1;
        state_next = ESPERA_OPCODE;
      end
      ESPERA_OPCODE: if (bus.i_rx_done) begin
        load_opcode = 1'b1;
        state_next  = ENVIO;
      end
      ENVIO: begin
        // i_tx_done here belongs to no transfer of ours and is ignored.
        send       = 1'b1;
        drop       = bus.i_rx_done;
        state_next = ESPERA_TX;
      end
      ESPERA_TX: begin
        drop = bus.i_rx_done;
        if (bus.i_tx_done) state_next = ESPERA_OP1;
      end
      default: state_next = ESPERA_OP1;  // unreachable encodings recover
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      operando_1_q <= '0;
      operando_2_q <= '0;
      opcode_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tx_start_q <= send;  // ENVIO lasts one cycle, so this is a single pulse
      if (load_op1)    operando_1_q <= bus.i_rx_data[CANT_BUS_ENTRADA-1:0];
      if (load_op2)    operando_2_q <= bus.i_rx_data[CANT_BUS_ENTRADA-1:0];
      if (load_opcode) opcode_q     <= bus.i_rx_data[CANT_BITS_OPCODE-1:0];
      if (send)        tx_data_q    <= result_ext;
      if (drop)        overrun_q    <= 1'b1;
    end
  end

  assign bus.o_operando_1 = operando_1_q;
  assign bus.o_operando_2 = operando_2_q;
  assign bus.o_opcode     = opcode_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_overrun    = overrun_q;
  assign bus.o_busy       = (state == ENVIO) || (state == ESPERA_TX);

endmodule
